// File: rtl/fetch_unit_pkg.sv
// Shared constants and entry layout for the instruction byte-fetch front end.
package fetch_unit_pkg;

  localparam int ROM_ADDR_WIDTH = 6;
  localparam int ROM_DATA_WIDTH = 8;

  // Fetch address taken out of reset.
  localparam logic [ROM_ADDR_WIDTH-1:0] RESET_VECTOR = '0;

  // One buffered byte together with the ROM address it was read from.
  typedef struct packed {
    logic [ROM_DATA_WIDTH-1:0] data;
    logic [ROM_ADDR_WIDTH-1:0] address;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO holding fetched {data, address} entries.
// The head entry is read combinationally. A flush empties the queue in one
// cycle. Storage is zeroed on reset so the head reads back as zero.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = ROM_DATA_WIDTH + ROM_ADDR_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty queue is ignored; a push into a full queue is dropped.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CNT_FULL);

  assign head = mem[rd_ptr];

  // Pointer, occupancy and storage update; flush beats push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential byte fetch from a registered program ROM into a small FIFO,
// presented to the decoder over valid/ready, with redirect-and-flush on jump.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = ROM_ADDR_WIDTH,
  parameter int                    DEPTH         = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = RESET_VECTOR
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [ADDR_WIDTH-1:0]     rom_address,
  input  logic [ROM_DATA_WIDTH-1:0] rom_data,
  input  logic                      jump,
  input  logic [ADDR_WIDTH-1:0]     jump_address,
  input  logic                      ready,
  output logic                      valid,
  output logic [ROM_DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0]     data_address,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ROM_DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE    = ADDR_WIDTH'(1);
  localparam logic [CNT_W:0]        CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  // p0: address presented to the ROM this cycle.
  logic [ADDR_WIDTH-1:0] fetch_pc;
  // p1: a read was issued last edge; its byte is on rom_data now.
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;

  logic                  issue;
  logic [ENTRY_W-1:0]    head;

  assign rom_address = fetch_pc;

  // Issue only when buffered plus in-flight bytes leave a free slot. A pop
  // in the same cycle is not credited, so the FIFO can never overflow.
  assign issue = (({1'b0, count} + {{CNT_W{1'b0}}, vld_p1}) < CREDIT_MAX);

  // Fetch address and in-flight flag; reset beats jump beats issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_ADDRESS;
      vld_p1   <= 1'b0;
    end else if (jump) begin
      fetch_pc <= jump_address;
      vld_p1   <= 1'b0;
    end else if (issue) begin
      fetch_pc <= fetch_pc + PC_ONE;
      vld_p1   <= 1'b1;
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  // Remember which address the in-flight byte belongs to.
  always_ff @(posedge clk) begin
    if (issue) begin
      addr_p1 <= fetch_pc;
    end
  end

  // p2: captured bytes wait in the FIFO for the decoder.
  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p1),
    .push_data ({rom_data, addr_p1}),
    .pop       (valid && ready),
    .flush     (jump),
    .head      (head),
    .count     (count)
  );

  assign valid        = (count != '0);
  assign data_out     = head[ADDR_WIDTH +: ROM_DATA_WIDTH];
  assign data_address = head[ADDR_WIDTH-1:0];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Sequential byte-fetch front end sitting directly upstream of the program ROM: drives the ROM's 6-bit address, captures its registered 8-bit output one clock later, and buffers fetched bytes in a small FIFO.
- Presents bytes to the CPU decoder over a valid/ready handshake.
- Supports redirect (jump) with flush of buffered and in-flight bytes.

Parameters:
- ADDR_WIDTH, 6, ROM address width; PC wraps modulo 2^ADDR_WIDTH.
- DEPTH, 4, FIFO entries (power of two, >= 2).
- RESET_ADDRESS, 0, fetch address loaded on reset.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_address  output  ADDR_WIDTH  address to ROM, driven directly from the fetch_pc register.
- rom_data  input  8  ROM registered read data, valid the cycle after its address is sampled.
- jump  input  1  redirect request, single-cycle pulse.
- jump_address  input  ADDR_WIDTH  redirect target, sampled when jump=1.
- ready  input  1  consumer accepts the head byte this cycle.
- valid  output  1  head byte available (count != 0).
- data_out  output  8  head byte.
- data_address  output  ADDR_WIDTH  ROM address the head byte came from.
- count  output  log2(DEPTH)+1  bytes currently buffered.

Behaviour:
- Reset (sync, at edge with reset=1):
  - fetch_pc=RESET_ADDRESS, pending=0, count=0, FIFO pointers=0.
  - All FIFO storage is cleared, so valid=0, data_out=0, data_address=0 and rom_address=RESET_ADDRESS.
  - reset overrides jump, ready and capture.
- ROM timing: the ROM samples rom_address at edge N; rom_data holds that byte after edge N; this block captures it at edge N+1.
- Issue:
  - At each edge where count + pending < DEPTH, set pending=1, pending_address=fetch_pc, and fetch_pc=fetch_pc+1 modulo 2^ADDR_WIDTH (63 -> 0).
  - Otherwise hold fetch_pc and set pending=0.
  - The credit check ignores a same-cycle pop, which is conservative.
- Capture: at an edge where pending=1 (from the previous edge), push {rom_data, pending_address} into the FIFO.
- Pop: at an edge where valid & ready, advance the read pointer.
  - Push and pop in the same cycle leave count unchanged.
  - ready with valid=0 is ignored.
- Overflow is impossible by the credit rule. The bench asserts count <= DEPTH at all times.
- Output: valid, data_out and data_address are combinational from the FIFO head and count. data_out is stable while valid=1 and ready=0.
- Jump (at edge with jump=1, reset=0):
  - count=0 and read and write pointers are reset.
  - pending=0, so the byte arriving on rom_data next cycle is discarded.
  - fetch_pc=jump_address.
  - Jump has priority over same-cycle issue, capture and pop. A pop in that cycle is lost; the consumer must not rely on it.
- Latency:
  - After reset deasserts (first edge with reset=0 = edge 1), the first byte is captured at edge 2 and valid=1 after edge 2.
  - After a jump at edge J, rom_address=jump_address after J, issue at J+1, capture at J+2, valid=1 after J+2.
- Steady state with ready=1 continuously: one byte per clock, consecutive addresses.
- Back-pressure: ready=0 fills the FIFO to DEPTH, then issue stops. rom_address holds the next unfetched address.
- Reset mid-operation: identical to power-on reset; in-flight data is discarded.

Decomposition:
- Shared package holds:
  - ROM_ADDR_WIDTH=6 and ROM_DATA_WIDTH=8.
  - RESET_VECTOR constant.
  - fetch entry layout: {data[7:0], address[5:0]}.
- One sub-module, fetch_fifo:
  - DEPTH-entry synchronous FIFO with push/pop/flush and a count output.
  - Combinational head read.
  - Storage cleared on reset.
- fetch_unit holds fetch_pc, pending, pending_address and the issue/credit logic.

Test Plan:
- ROM loaded with memory[i]=i+0x10, RESET_ADDRESS=0, ready=1, release reset -> valid rises after edge 2; bytes 0x10,0x11,0x12... one per clock; data_address 0,1,2...
- ready=0 after reset -> count reaches 4 and stays; rom_address holds 4; no further issue. Then ready=1 -> bytes 0x10..0x13 then 0x14 with no gap or duplicate.
- Jump to 0x3E during streaming, with a ready pop in the same cycle -> count=0 after the jump edge; the in-flight byte is discarded; next bytes 0x4E (addr 62), 0x4F (addr 63), then 0x10 (addr 0 wrap).
- Jump asserted while FIFO full and ready=0 -> flushed; valid=1 two edges later with data at jump_address.
- Reset asserted for one cycle mid-stream with jump also high -> reset wins; rom_address=0, count=0, valid=0, data_out=0; the stream restarts at 0x10.
- Random ready toggling over 500 cycles against a scoreboard -> byte sequence exactly matches sequential ROM contents, no loss or duplication, count <= 4 always.
